// File: rtl/scmp_mem_pkg.sv
// ----------------------------------------------------------------------------
// scmp_mem_pkg
// Shared types and constants for the SC/MP on-chip RAM arbiter.
//   arb_state_t : arbiter FSM states (IDLE, CPU_RD, DBG_RD)
//   MEM_SIZE    : depth of the on-chip RAM in bytes
// ----------------------------------------------------------------------------
package scmp_mem_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      CPU_RD = 2'd1,
      DBG_RD = 2'd2
   } arb_state_t;

   localparam int MEM_SIZE = 128;

endpackage

// File: rtl/scmp_strobe_edge.sv
// ----------------------------------------------------------------------------
// scmp_strobe_edge
// Falling-edge detector for one active-low SC/MP bus strobe.
// Ports:
//   i_clk     : CPU clock
//   i_rst     : asynchronous active-high reset
//   i_strobeN : live active-low strobe from the CPU
//   o_fall    : high in the cycle the strobe is first seen low
// ----------------------------------------------------------------------------
module scmp_strobe_edge
   import scmp_mem_pkg::*;
(
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_strobeN,
   output logic o_fall
);

   logic r_strobeQ;

   // Previous-cycle copy of the strobe. It resets to the inactive level so a
   // strobe that is already low when reset is released counts as a new edge.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_strobeQ <= 1'b1;
      end else begin
         r_strobeQ <= i_strobeN;
      end
   end

   assign o_fall = ~i_strobeN & r_strobeQ;

endmodule

// File: rtl/scmp_mem_arbiter.sv
// ----------------------------------------------------------------------------
// scmp_mem_arbiter
// Shares one synchronous single-port RAM between the SC/MP CPU bus and a
// debug/loader port. The CPU always wins; the debug port is served only in
// idle bus slots through a level req / one-cycle ack handshake.
// Ports:
//   i_clk, i_rst                 : clock, asynchronous active-high reset
//   i_cpuAddr, i_cpuDO           : CPU address (low ADDR_W bits used), write data
//   i_cpuRdN/i_cpuWrN/i_cpuAdsN  : CPU strobes, active low
//   o_cpuDI                      : read data returned to the CPU
//   i_dbgReq/i_dbgWe/i_dbgAddr/i_dbgWdata : debug request side
//   o_dbgAck, o_dbgRdata         : debug completion pulse and read data
//   o_dbgStarved                 : sticky flag, debug request waited too long
//   o_ramEn/o_ramWe/o_ramAddr/o_ramWdata/i_ramRdata : RAM port (1-cycle read)
// ----------------------------------------------------------------------------
module scmp_mem_arbiter
   import scmp_mem_pkg::*;
#(
   parameter int ADDR_W      = 7,
   parameter int DATA_W      = 8,
   parameter int STALL_LIMIT = 255
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic [11:0]       i_cpuAddr,
   input  logic [DATA_W-1:0] i_cpuDO,
   input  logic              i_cpuRdN,
   input  logic              i_cpuWrN,
   input  logic              i_cpuAdsN,
   output logic [DATA_W-1:0] o_cpuDI,
   input  logic              i_dbgReq,
   input  logic              i_dbgWe,
   input  logic [ADDR_W-1:0] i_dbgAddr,
   input  logic [DATA_W-1:0] i_dbgWdata,
   output logic              o_dbgAck,
   output logic [DATA_W-1:0] o_dbgRdata,
   output logic              o_dbgStarved,
   output logic              o_ramEn,
   output logic              o_ramWe,
   output logic [ADDR_W-1:0] o_ramAddr,
   output logic [DATA_W-1:0] o_ramWdata,
   input  logic [DATA_W-1:0] i_ramRdata
);

   localparam int CNT_W = $clog2(STALL_LIMIT + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STALL_LIMIT);

   arb_state_t        r_state;
   logic              r_pendRd, r_pendWr;
   logic [ADDR_W-1:0] r_cpuAddrL;
   logic [DATA_W-1:0] r_cpuDataL;
   logic [DATA_W-1:0] r_holdQ;
   logic [CNT_W-1:0]  r_stallCnt;

   logic              w_rdFall, w_wrFall;
   logic              w_run, w_idle, w_rdReq, w_wrReq;
   logic              w_cpuWr, w_cpuRd, w_dbgGrant;
   logic [ADDR_W-1:0] w_liveAddr;
   logic              w_unusedAddr;

   scmp_strobe_edge u_rdEdge (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .i_strobeN (i_cpuRdN),
      .o_fall    (w_rdFall)
   );

   scmp_strobe_edge u_wrEdge (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .i_strobeN (i_cpuWrN),
      .o_fall    (w_wrFall)
   );

   assign w_liveAddr   = i_cpuAddr[ADDR_W-1:0];
   assign w_unusedAddr = ^i_cpuAddr[11:ADDR_W];

   // Issue decision. Gating with reset keeps a strobe that is low during
   // reset (edge detector reads it as an edge) from reaching the RAM, and
   // kills an in-flight write the moment reset rises.
   assign w_run      = ~i_rst;
   assign w_idle     = (r_state == IDLE);
   assign w_wrReq    = r_pendWr | w_wrFall;
   assign w_rdReq    = r_pendRd | w_rdFall;
   assign w_cpuWr    = w_run & w_idle & w_wrReq;
   assign w_cpuRd    = w_run & w_idle & ~w_wrReq & w_rdReq;
   assign w_dbgGrant = w_run & w_idle & ~w_wrReq & ~w_rdReq & i_cpuRdN & i_cpuWrN
                       & i_cpuAdsN & i_dbgReq & ~o_dbgAck;

   // RAM port mux. A pending request uses the address/data latched at its
   // edge; a fresh one uses the live bus.
   always_comb begin
      o_ramEn    = w_cpuWr | w_cpuRd | w_dbgGrant;
      o_ramWe    = w_cpuWr | (w_dbgGrant & i_dbgWe);
      o_ramAddr  = '0;
      o_ramWdata = '0;
      if (w_cpuWr) begin
         o_ramAddr  = r_pendWr ? r_cpuAddrL : w_liveAddr;
         o_ramWdata = r_pendWr ? r_cpuDataL : i_cpuDO;
      end else if (w_cpuRd) begin
         o_ramAddr  = r_pendRd ? r_cpuAddrL : w_liveAddr;
      end else if (w_dbgGrant) begin
         o_ramAddr  = i_dbgAddr;
         o_ramWdata = i_dbgWdata;
      end
   end

   // CPU read data: straight from the RAM in the read cycle, then the held
   // copy for as long as the CPU keeps its read strobe low, else idle bus.
   always_comb begin
      if (r_state == CPU_RD) begin
         o_cpuDI = i_ramRdata;
      end else if (!i_cpuRdN) begin
         o_cpuDI = r_holdQ;
      end else begin
         o_cpuDI = '1;
      end
   end

   // Edge latch and pending flags. An edge that cannot be issued this cycle
   // (arbiter busy, or a higher-priority CPU request issuing) stays pending.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_cpuAddrL <= '0;
         r_cpuDataL <= '0;
         r_pendRd   <= 1'b0;
         r_pendWr   <= 1'b0;
      end else begin
         if (w_rdFall || w_wrFall) begin
            r_cpuAddrL <= w_liveAddr;
            r_cpuDataL <= i_cpuDO;
         end
         r_pendWr <= w_wrReq & ~w_cpuWr;
         r_pendRd <= w_rdReq & ~w_cpuRd;
      end
   end

   // Arbiter FSM with its registered outputs. Read states last one cycle,
   // which is exactly where the 1-cycle-latency RAM data appears.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state    <= IDLE;
         r_holdQ    <= '1;
         o_dbgRdata <= '0;
         o_dbgAck   <= 1'b0;
      end else begin
         o_dbgAck <= (r_state == DBG_RD) | (w_dbgGrant & i_dbgWe);
         case (r_state)
            IDLE: begin
               if (w_cpuRd) begin
                  r_state <= CPU_RD;
               end else if (w_dbgGrant && !i_dbgWe) begin
                  r_state <= DBG_RD;
               end
            end
            CPU_RD: begin
               r_holdQ <= i_ramRdata;
               r_state <= IDLE;
            end
            DBG_RD: begin
               o_dbgRdata <= i_ramRdata;
               r_state    <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   // Starvation counter: runs while a debug request waits, saturates at the
   // limit so the flag stays up until the request is finally acknowledged.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_stallCnt <= '0;
      end else if (o_dbgAck) begin
         r_stallCnt <= '0;
      end else if (i_dbgReq && !w_dbgGrant && r_stallCnt != CNT_MAX) begin
         r_stallCnt <= r_stallCnt + 1'b1;
      end
   end

   assign o_dbgStarved = (r_stallCnt == CNT_MAX);

endmodule

// File: doc/scmp_mem_arbiter.md
# scmp_mem_arbiter

Shares the single-port 128-byte on-chip RAM between the SC/MP CPU bus and a debug/loader port (UART monitor, test harness). The CPU always has priority. The debug port is served only in idle bus slots through a req/ack handshake. The block sits between `scmp` and the RAM macro on the board top and replaces direct strobe-driven array access with one synchronous RAM port.

## Interface
- `ADDR_W`, default 7: RAM address width. RAM depth is 2**ADDR_W, and CPU addresses wrap modulo that depth.
- `DATA_W`, default 8: data width.
- `STALL_LIMIT`, default 255: number of cycles a debug request may wait before `dbg_starved` asserts.

Ports:
- `clk` in 1: CPU clock; every input is synchronous to it.
- `rst` in 1: asynchronous, active-high reset.
- `cpu_addr` in 12: CPU address; only `[ADDR_W-1:0]` is used.
- `cpu_d_o` in DATA_W: CPU write data.
- `cpu_rd_n`, `cpu_wr_n`, `cpu_ads_n` in 1 each: CPU strobes, active low.
- `cpu_d_i` out DATA_W: read data to the CPU.
- `dbg_req` in 1: debug request, level.
- `dbg_we` in 1: 1 = write, 0 = read.
- `dbg_addr` in ADDR_W: debug address.
- `dbg_wdata` in DATA_W: debug write data.
- `dbg_ack` out 1: one-cycle completion pulse.
- `dbg_rdata` out DATA_W: debug read data, valid while `dbg_ack` = 1.
- `dbg_starved` out 1: sticky flag; the request has waited ≥ STALL_LIMIT cycles.
- `ram_en`, `ram_we` out 1: RAM port strobes.
- `ram_addr` out ADDR_W: RAM address.
- `ram_wdata` out DATA_W: RAM write data.
- `ram_rdata` in DATA_W: RAM read data; the RAM is synchronous with 1-cycle read latency.

## Operation
- Edge detect: registered copies `rd_q`/`wr_q` (reset value 1). A falling edge is a sampled cycle with `strobe=0` and `q=1`. On each edge, `cpu_addr` and `cpu_d_o` are latched into `cpu_addr_l`/`cpu_data_l`.
- FSM states: IDLE, CPU_RD, DBG_RD. Reset state is IDLE. CPU_RD and DBG_RD each last exactly 1 cycle, then return to IDLE.
- Issue happens only in IDLE. Priority order: pending/fresh CPU write > pending/fresh CPU read > debug.
  - CPU write: `ram_en=ram_we=1`, data from the latch or the live bus. State stays IDLE.
  - CPU read: `ram_en=1`; next state CPU_RD.
  - Debug: granted only when all of the following hold: `cpu_rd_n`, `cpu_wr_n` and `cpu_ads_n` are all 1; no pending CPU request; `dbg_ack`=0.
    - Debug write: `ram_we=1`; `dbg_ack` is registered 1 in the next cycle.
    - Debug read: next state DBG_RD.
- Pending flags `pend_rd`/`pend_wr` are set when an edge arrives outside IDLE. They are cleared when served. Worst-case added CPU latency is 1 cycle.
- `cpu_d_i` selection:
  - In CPU_RD: `ram_rdata`.
  - Otherwise, while `cpu_rd_n`=0: `hold_q`.
  - Otherwise: 8'hFF.
  - `hold_q` loads `ram_rdata` at the end of CPU_RD and resets to 8'hFF.
- Debug read: in DBG_RD, `dbg_rdata` ← `ram_rdata` (registered), and `dbg_ack`=1 in the following cycle. `dbg_rdata` resets to 0 and holds its value otherwise.
- Starvation counter: increments each cycle `dbg_req`=1 without a grant, saturating at STALL_LIMIT. `dbg_starved`=1 at the limit. The counter and flag clear on `dbg_ack`.
- Reset values: all RAM strobes 0; `dbg_ack` 0; `dbg_starved` 0; pending flags 0; `cpu_d_i` 8'hFF (strobes high). `ram_en`/`ram_we` are combinational from registered state, so asserting `rst` kills an in-flight write immediately and discards any pending ack.

## Timing
- CPU read: edge sampled in cycle k → `ram_en` in cycle k. `cpu_d_i` is valid from cycle k+1 and holds while `cpu_rd_n`=0.
- CPU write: RAM is written at the end of cycle k, or k+1 if the request was pending.
- CPU strobes must stay low ≥ 3 cycles.
- Debug: the requester holds `dbg_req`, `dbg_addr` and `dbg_wdata` stable until `dbg_ack` and drops `dbg_req` in the ack cycle. A request still high in the cycle after ack starts a new transaction.
  - Write ack: grant cycle g+1.
  - Read ack with data: g+2.
- Simultaneous CPU edge and debug grant candidate: the CPU wins. The debug request waits and its counter runs.

## Structure
- Package `scmp_mem_pkg`: `arb_state_t` enum (IDLE, CPU_RD, DBG_RD) and `MEM_SIZE = 128`.
- Sub-module `scmp_strobe_edge`: holds the reset-to-1 registered strobe and produces the falling-edge pulse. It is instantiated twice, for rd and wr.

## Test plan
- Reset, then `cpu_rd_n`=1 → `cpu_d_i`=8'hFF, `ram_en`=0, `dbg_ack`=0.
- CPU write 8'h5A @ 12'h0C5 (wraps to 7'h45), then a CPU read of 12'hFC5 → `ram_addr`=7'h45 and `cpu_d_i`=8'h5A one cycle after the read edge.
- Debug write 8'h33 @ 7'h10 while the CPU is idle → ack at g+1. Debug read of 7'h10 → `dbg_rdata`=8'h33 with ack at g+2.
- `dbg_req` asserted in the same cycle as a CPU read edge → CPU served first; debug granted only after `cpu_rd_n` rises; no lost or duplicate ack.
- CPU wr edge arrives during DBG_RD → pending write lands 1 cycle later with the latched data; debug read data is correct.
- CPU strobes held low continuously for 300 cycles with `dbg_req`=1 → `dbg_starved`=1 at cycle 255; it clears on the eventual ack. Asserting `rst` mid-transaction → no ack and `ram_we`=0 immediately.
